// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous ram between two
// requesters. After every reset it zero-fills the ram before serving requests.
// All ram control pins are registered here. Read data is routed back to its
// owner through a two-stage tag pipe that matches the ram read latency.
module ram_rr_arbiter #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10,
  parameter int INIT_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // requester 0
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [RAM_WIDTH-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [RAM_WIDTH-1:0] m0_rdata,
  // requester 1
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [RAM_WIDTH-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [RAM_WIDTH-1:0] m1_rdata,
  // status
  output logic                 init_done,
  // ram side
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_wr_add,
  output logic [ADDR_SIZE-1:0] ram_rd_add,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Depth widened by one bit so that both the fill counter and the
  // out-of-range check work even when RAM_DEPTH == 2**ADDR_SIZE.
  localparam logic [ADDR_SIZE:0] DEPTH_W   = (ADDR_SIZE + 1)'(RAM_DEPTH);
  localparam state_t             RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_reg;
  logic [ADDR_SIZE:0]     init_cnt_reg;
  logic                   init_done_reg;
  logic                   rr_last_reg;      // id of the requester granted last

  logic                   ram_wr_en_reg;
  logic                   ram_rd_en_reg;
  logic [ADDR_SIZE-1:0]   ram_wr_add_reg;
  logic [ADDR_SIZE-1:0]   ram_rd_add_reg;
  logic [RAM_WIDTH-1:0]   ram_data_in_reg;

  // Tag pipe: stage 1 lines up with the registered rd_en, stage 2 with the
  // cycle in which ram_data_out carries the sampled word.
  logic                   tag1_valid_reg;
  logic                   tag1_id_reg;
  logic                   tag1_oor_reg;
  logic                   tag2_valid_reg;
  logic                   tag2_id_reg;
  logic                   tag2_oor_reg;

  // ---------------------------------------------------------------------------
  // Requester vectors (index = requester id)
  // ---------------------------------------------------------------------------
  logic [1:0]             req_vec;
  logic [1:0]             we_vec;
  logic [1:0]             gnt_vec;
  logic [ADDR_SIZE-1:0]   addr_vec  [2];
  logic [RAM_WIDTH-1:0]   wdata_vec [2];

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign addr_vec[0]  = m0_addr;
  assign addr_vec[1]  = m1_addr;
  assign wdata_vec[0] = m0_wdata;
  assign wdata_vec[1] = m1_wdata;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                   serve_en;
  logic                   acc_valid;
  logic                   acc_id;
  logic                   acc_we;
  logic [ADDR_SIZE-1:0]   acc_addr;
  logic [RAM_WIDTH-1:0]   acc_wdata;
  logic                   acc_in_range;

  // Grants are only issued once the fill has finished; init_done_reg also
  // keeps the very first cycle after reset quiet when the fill is disabled.
  assign serve_en = init_done_reg && (state_reg == ST_RUN);

  // Round-robin grant: a lone requester wins; on a tie the one not granted
  // last wins.
  always_comb begin
    gnt_vec    = 2'b00;
    gnt_vec[0] = serve_en && req_vec[0] && (!req_vec[1] || rr_last_reg);
    gnt_vec[1] = serve_en && req_vec[1] && (!req_vec[0] || !rr_last_reg);
  end

  assign m0_gnt = gnt_vec[0];
  assign m1_gnt = gnt_vec[1];

  // Mux the accepted access; gnt_vec is one-hot or zero.
  assign acc_valid    = |gnt_vec;
  assign acc_id       = gnt_vec[1];
  assign acc_we       = we_vec[acc_id];
  assign acc_addr     = addr_vec[acc_id];
  assign acc_wdata    = wdata_vec[acc_id];
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_W);

  // ---------------------------------------------------------------------------
  // Control FSM: zero-fill sweep, then registered ram strobes for accepts
  // ---------------------------------------------------------------------------
  // FSM with registered ram strobes, fill counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RST_STATE;
      init_cnt_reg    <= '0;
      init_done_reg   <= 1'b0;
      rr_last_reg     <= 1'b1;
      ram_wr_en_reg   <= 1'b0;
      ram_rd_en_reg   <= 1'b0;
      ram_wr_add_reg  <= '0;
      ram_rd_add_reg  <= '0;
      ram_data_in_reg <= '0;
    end else begin
      // strobes are single-cycle unless re-armed below
      ram_wr_en_reg <= 1'b0;
      ram_rd_en_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg < DEPTH_W) begin
            ram_wr_en_reg   <= 1'b1;
            ram_wr_add_reg  <= init_cnt_reg[ADDR_SIZE-1:0];
            ram_data_in_reg <= '0;
            init_cnt_reg    <= init_cnt_reg + 1'b1;
          end else begin
            // last zero write is on the pins now; start serving next cycle
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_reg <= 1'b1;
          if (acc_valid) begin
            rr_last_reg <= acc_id;
            // out-of-range accesses are accepted but never reach the ram
            if (acc_in_range) begin
              if (acc_we) begin
                ram_wr_en_reg   <= 1'b1;
                ram_wr_add_reg  <= acc_addr;
                ram_data_in_reg <= acc_wdata;
              end else begin
                ram_rd_en_reg  <= 1'b1;
                ram_rd_add_reg <= acc_addr;
              end
            end
          end
        end
        default: state_reg <= RST_STATE;
      endcase
    end
  end

  assign ram_wr_en   = ram_wr_en_reg;
  assign ram_rd_en   = ram_rd_en_reg;
  assign ram_wr_add  = ram_wr_add_reg;
  assign ram_rd_add  = ram_rd_add_reg;
  assign ram_data_in = ram_data_in_reg;
  assign init_done   = init_done_reg;

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  // Two-deep tag pipe carrying {valid, owner id, out-of-range} for reads;
  // reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_valid_reg <= 1'b0;
      tag1_id_reg    <= 1'b0;
      tag1_oor_reg   <= 1'b0;
      tag2_valid_reg <= 1'b0;
      tag2_id_reg    <= 1'b0;
      tag2_oor_reg   <= 1'b0;
    end else begin
      tag1_valid_reg <= acc_valid && !acc_we;
      tag1_id_reg    <= acc_id;
      tag1_oor_reg   <= !acc_in_range;
      tag2_valid_reg <= tag1_valid_reg;
      tag2_id_reg    <= tag1_id_reg;
      tag2_oor_reg   <= tag1_oor_reg;
    end
  end

  // One return register set per requester; rdata holds until its next rvalid.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      logic                 rvalid_reg;
      logic [RAM_WIDTH-1:0] rdata_reg;
      logic                 hit;

      assign hit = tag2_valid_reg && (tag2_id_reg == 1'(gi));

      // Capture ram_data_out (or zero for an out-of-range read) for this owner.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= hit;
          if (hit) begin
            rdata_reg <= tag2_oor_reg ? '0 : ram_data_out;
          end
        end
      end
    end
  endgenerate

  assign m0_rvalid = g_ret[0].rvalid_reg;
  assign m0_rdata  = g_ret[0].rdata_reg;
  assign m1_rvalid = g_ret[1].rvalid_reg;
  assign m1_rdata  = g_ret[1].rdata_reg;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a small behavioural ram attached.
// Table rows drive both requesters for one cycle each; hand sequences cover
// the zero-fill sweep and reset during an in-flight read.
module tb_ram_rr_arbiter;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [A-1:0] m0_addr, m1_addr;
  logic [W-1:0] m0_wdata, m1_wdata;
  logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, init_done;
  logic [W-1:0] m0_rdata, m1_rdata;
  logic         ram_wr_en, ram_rd_en;
  logic [A-1:0] ram_wr_add, ram_rd_add;
  logic [W-1:0] ram_data_in, ram_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_rr_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A), .INIT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .init_done(init_done),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_wr_add(ram_wr_add), .ram_rd_add(ram_rd_add),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural single-port ram, 32 words so out-of-range writes would be
  // visible; preloaded with 0xEE so the zero-fill is observable.
  logic [W-1:0] mem [32];
  logic         preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hEE;
      ram_data_out <= 8'hEE;
    end else begin
      if (ram_wr_en) mem[ram_wr_add] <= ram_data_in;
      if (ram_rd_en) ram_data_out <= mem[ram_rd_add];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         r0, we0; logic [A-1:0] a0; logic [W-1:0] d0;
    logic         r1, we1; logic [A-1:0] a1; logic [W-1:0] d1;
    logic         g0, g1;                       // before the edge
    logic         done, wr, rd; logic [A-1:0] add; logic [W-1:0] din; // after
    logic         v0, v1; logic [W-1:0] q0, q1;                       // after
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic r0, we0, input logic [A-1:0] a0, input logic [W-1:0] d0,
    input logic r1, we1, input logic [A-1:0] a1, input logic [W-1:0] d1,
    input logic g0, g1, input logic wr, rd, input logic [A-1:0] ad,
    input logic [W-1:0] din, input logic v0, v1, input logic [W-1:0] q0, q1);
    vec_t v;
    v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.done = 1'b1; v.wr = wr; v.rd = rd;
    v.add = ad; v.din = din; v.v0 = v0; v.v1 = v1; v.q0 = q0; v.q1 = q1;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  initial begin
    int lat;
    int seen;
    //       r0 we a0 d0     r1 we a1 d1     g0 g1 wr rd add din    v0 v1 q0     q1
    add_vec(1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00); // 0 fill tail
    add_vec(1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 1, 7, 8'h00, 0, 0, 8'h00, 8'h00); // 1 m0 rd 7
    add_vec(1, 1, 3, 8'hAA, 0, 0, 0, 8'h00, 1, 0, 1, 0, 3, 8'hAA, 0, 0, 8'h00, 8'h00); // 2 m0 wr 3
    add_vec(1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 1, 3, 8'h00, 1, 0, 8'h00, 8'h00); // 3 m0 rd 3
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00); // 4
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 8'hAA, 8'h00); // 5 RAW data
    add_vec(1, 0, 3, 8'h00, 1, 0, 7, 8'h00, 0, 1, 0, 1, 7, 8'h00, 0, 0, 8'hAA, 8'h00); // 6 both
    add_vec(1, 0, 3, 8'h00, 1, 0, 7, 8'h00, 1, 0, 0, 1, 3, 8'h00, 0, 0, 8'hAA, 8'h00); // 7
    add_vec(1, 0, 3, 8'h00, 1, 0, 7, 8'h00, 0, 1, 0, 1, 7, 8'h00, 0, 1, 8'hAA, 8'h00); // 8
    add_vec(1, 0, 3, 8'h00, 1, 0, 7, 8'h00, 1, 0, 0, 1, 3, 8'h00, 1, 0, 8'hAA, 8'h00); // 9
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 8'hAA, 8'h00); // 10
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 8'hAA, 8'h00); // 11
    add_vec(0, 0, 0, 8'h00, 1, 1, 5, 8'h55, 0, 1, 1, 0, 5, 8'h55, 0, 0, 8'hAA, 8'h00); // 12 m1 wr 5
    add_vec(1, 0, 5, 8'h00, 1, 0, 5, 8'h00, 1, 0, 0, 1, 5, 8'h00, 0, 0, 8'hAA, 8'h00); // 13 both rd 5
    add_vec(1, 0, 5, 8'h00, 1, 0, 5, 8'h00, 0, 1, 0, 1, 5, 8'h00, 0, 0, 8'hAA, 8'h00); // 14
    add_vec(1, 0, 5, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 1, 5, 8'h00, 1, 0, 8'h55, 8'h00); // 15
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 8'h55, 8'h55); // 16
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h55, 8'h55); // 17
    add_vec(1, 0, 20, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h55, 8'h55); // 18 oor rd
    add_vec(0, 0, 0, 8'h00, 1, 1, 20, 8'h77, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h55, 8'h55); // 19 oor wr
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h55); // 20 oor data
    add_vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h55); // 21

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m0_req = 1; m0_we = 0; m0_addr = 7;   // held through the whole fill
    #1;
    chk("rst init_done", init_done, 0);
    chk("rst m0_gnt", m0_gnt, 0);
    chk("rst wr_en", ram_wr_en, 0);
    chk("rst rd_en", ram_rd_en, 0);
    chk("rst wr_add", ram_wr_add, 0);
    chk("rst rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst rdata", {m0_rdata, m1_rdata}, 0);
    $display("reset state checked");
    rst = 1'b0;

    // ---------------- zero-fill sweep ----------------
    for (int c = 1; c <= D; c++) begin
      @(posedge clk);
      #1;
      chk("fill wr_en", ram_wr_en, 1);
      chk("fill wr_add", ram_wr_add, c - 1);
      chk("fill data_in", ram_data_in, 0);
      chk("fill init_done", init_done, 0);
      chk("fill m0_gnt", m0_gnt, 0);
      $display("fill cycle %0d wr_add=%0d", c, ram_wr_add);
    end

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      m0_req = vecs[i].r0; m0_we = vecs[i].we0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
      m1_req = vecs[i].r1; m1_we = vecs[i].we1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
      #1;
      chk($sformatf("v%0d m0_gnt", i), m0_gnt, vecs[i].g0);
      chk($sformatf("v%0d m1_gnt", i), m1_gnt, vecs[i].g1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d init_done", i), init_done, vecs[i].done);
      chk($sformatf("v%0d wr_en", i), ram_wr_en, vecs[i].wr);
      chk($sformatf("v%0d rd_en", i), ram_rd_en, vecs[i].rd);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d wr_add", i), ram_wr_add, vecs[i].add);
        chk($sformatf("v%0d data_in", i), ram_data_in, vecs[i].din);
      end
      if (vecs[i].rd) chk($sformatf("v%0d rd_add", i), ram_rd_add, vecs[i].add);
      chk($sformatf("v%0d m0_rvalid", i), m0_rvalid, vecs[i].v0);
      chk($sformatf("v%0d m1_rvalid", i), m1_rvalid, vecs[i].v1);
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].q0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].q1);
      $display("vec %0d: gnt=%b%b wr=%b rd=%b rv=%b%b q0=%h q1=%h",
               i, m1_gnt, m0_gnt, ram_wr_en, ram_rd_en, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata);
    end
    chk("oor write kept ram", mem[20], 8'hEE);

    // ---------------- reset with a read in flight ----------------
    idle_inputs();
    m0_req = 1; m0_we = 0; m0_addr = 3;
    #1 chk("pre-rst m0_gnt", m0_gnt, 1);
    @(posedge clk);
    #1;
    chk("pre-rst rd_en", ram_rd_en, 1);
    m0_req = 0;
    rst = 1'b1;
    #1;
    chk("async rst rd_en", ram_rd_en, 0);
    chk("async rst init_done", init_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    @(posedge clk);
    #1;
    chk("re-init wr_en", ram_wr_en, 1);
    chk("re-init wr_add", ram_wr_add, 0);
    if (m0_rvalid || m1_rvalid) seen++;
    lat = 0;
    while (!init_done && lat < 40) begin
      @(posedge clk);
      #1;
      if (m0_rvalid || m1_rvalid) seen++;
      lat++;
    end
    chk("re-init done in time", init_done, 1);
    chk("no rvalid after rst", seen, 0);
    $display("reset mid-read: re-init took %0d cycles, stray rvalids=%0d", lat + 1, seen);

    m0_req = 1; m0_we = 0; m0_addr = 3;
    #1 chk("post-rst m0_gnt", m0_gnt, 1);
    @(posedge clk);
    #1 m0_req = 0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!m0_rvalid && lat < 6);
    chk("post-rst rd latency", lat, 2);
    chk("post-rst rdata", m0_rdata, 8'h00);
    $display("post-reset read @3: latency=%0d rdata=%h", lat, m0_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
